// File: rtl/detect_sched_pkg.sv
// Shared types and frame geometry for the detection scheduler.
// Pulled in by the scheduler top and its testbench.
package detect_sched_pkg;

  localparam int IMG_WIDTH  = 8;
  localparam int IMG_HEIGHT = 4;
  localparam int N_PIXELS   = IMG_WIDTH * IMG_HEIGHT;
  localparam int W_PIX      = $clog2(N_PIXELS);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    RUN,
    DONE
  } ctrl_state_t;

  function automatic logic [15:0] sat_inc16(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/detect_sched_fifo.sv
// Synchronous detection FIFO with an extra pointer bit for full/empty.
// Pop on empty is ignored; a pop frees space for a push in the same cycle.
module det_fifo #(
  parameter int W_DATA = 32,
  parameter int DEPTH  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              push_i,
  input  logic [W_DATA-1:0] wdata_i,
  output logic              full_o,
  input  logic              pop_i,
  output logic [W_DATA-1:0] rdata_o,
  output logic              empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wr_q, wr_d;
  logic [AW:0]       rd_q, rd_d;
  logic [W_DATA-1:0] mem_q [DEPTH];
  logic              do_pop;
  logic              do_push;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  // Pointer next-state: clear wins over any traffic.
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (clr_i) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage array, written on accepted pushes only.
  always_ff @(posedge clk_i) begin
    if (do_push && !clr_i) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/detect_sched.sv
// Frame scheduler: gates host pixels into the core, collects detections,
// bounds the run with a watchdog and raises a sticky end-of-frame irq.
module detect_sched
  import detect_sched_pkg::*;
#(
  parameter int W_DATA         = 8,
  parameter int W_POS          = 32,
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 2**20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              irq_ack,
  output logic              busy,
  output logic              done_irq,
  output logic              overflow,
  output logic              timeout,
  output logic [15:0]       det_count,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic              host_eot,
  input  logic [W_DATA-1:0] host_data,
  output logic              core_img_valid,
  input  logic              core_img_ready,
  output logic              core_img_eot,
  output logic [W_DATA-1:0] core_img_data,
  output logic              core_rst,
  input  logic              core_pos_valid,
  output logic              core_pos_ready,
  input  logic              core_pos_eot,
  input  logic [W_POS-1:0]  core_pos,
  output logic              det_valid,
  input  logic              det_ready,
  output logic [W_POS-1:0]  det_data
);

  localparam int W_WD = $clog2(TIMEOUT_CYCLES);
  localparam logic [W_WD-1:0] WD_MAX = W_WD'(TIMEOUT_CYCLES - 1);
  localparam logic [W_PIX-1:0] PIX_LAST = W_PIX'(N_PIXELS - 1);

  ctrl_state_t      state_q, state_d;
  logic             clr_cnt_q, clr_cnt_d;
  logic [W_PIX-1:0] pix_q, pix_d;
  logic [W_WD-1:0]  wd_q, wd_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             tmo_q, tmo_d;
  logic             irq_q, irq_d;

  logic in_clear, in_load, in_run;
  logic pix_last, img_hs, pos_hs, det_hs, drop;
  logic fifo_full, fifo_empty;

  assign in_clear = (state_q == CLEAR);
  assign in_load  = (state_q == LOAD);
  assign in_run   = (state_q == RUN);

  assign busy     = in_clear | in_load | in_run;
  assign core_rst = ~(in_load | in_run);
  assign done_irq = irq_q;
  assign overflow = ovf_q;
  assign timeout  = tmo_q;
  assign det_count = cnt_q;

  assign pix_last       = (pix_q == PIX_LAST);
  assign host_ready     = in_load & core_img_ready;
  assign core_img_valid = in_load & host_valid;
  assign core_img_eot   = in_load & (host_eot | pix_last);
  assign core_img_data  = in_load ? host_data : '0;
  assign img_hs         = in_load & host_valid & core_img_ready;

  assign core_pos_ready = in_run;
  assign pos_hs = in_run & core_pos_valid;
  assign det_hs = pos_hs & ~core_pos_eot;
  assign drop   = det_hs & fifo_full & ~det_ready;

  assign det_valid = ~fifo_empty;

  det_fifo #(
    .W_DATA (W_POS),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .clr_i   (in_clear),
    .push_i  (det_hs),
    .wdata_i (core_pos),
    .full_o  (fifo_full),
    .pop_i   (det_ready),
    .rdata_o (det_data),
    .empty_o (fifo_empty)
  );

  // Next-state, counters and sticky flags.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    pix_d     = pix_q;
    wd_d      = wd_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    tmo_d     = tmo_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = CLEAR;
          clr_cnt_d = 1'b0;
        end
      end
      CLEAR: begin
        cnt_d = '0;
        ovf_d = 1'b0;
        tmo_d = 1'b0;
        pix_d = '0;
        if (clr_cnt_q) state_d = LOAD;
        else clr_cnt_d = 1'b1;
      end
      LOAD: begin
        if (img_hs) begin
          pix_d = pix_q + W_PIX'(1);
          if (host_eot || pix_last) begin
            state_d = RUN;
            wd_d    = '0;
          end
        end
      end
      RUN: begin
        wd_d = wd_q + W_WD'(1);
        if (det_hs) cnt_d = sat_inc16(cnt_q);
        if (drop) ovf_d = 1'b1;
        if (pos_hs && core_pos_eot) begin
          state_d = DONE;
        end else if (wd_q == WD_MAX) begin
          state_d = DONE;
          tmo_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Interrupt: set on DONE entry beats a same-cycle ack.
  always_comb begin
    irq_d = irq_q;
    if (state_d == DONE && state_q != DONE) irq_d = 1'b1;
    else if (irq_ack) irq_d = 1'b0;
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      clr_cnt_q <= 1'b0;
      pix_q     <= '0;
      wd_q      <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      tmo_q     <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      pix_q     <= pix_d;
      wd_q      <= wd_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      tmo_q     <= tmo_d;
      irq_q     <= irq_d;
    end
  end

endmodule
